// File: rtl/modn_cascade_counter.sv
// Cascaded modulo-N digit counter: single-cycle up/down steps across the whole chain, parallel load, carry/borrow.
// Defining MODN_CASCADE_CMP_EN adds the cmp_val input and the registered match pulse.
module modn_cascade_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DIGIT_MAX = 16'h5959
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inc,
  input  logic                          dec,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
`ifdef MODN_CASCADE_CMP_EN
  input  logic [NUM_DIGITS*DIGIT_W-1:0] cmp_val,
  output logic                          match,
`endif
  output logic [NUM_DIGITS*DIGIT_W-1:0] q,
  output logic                          carry_out,
  output logic                          borrow_out,
  output logic [NUM_DIGITS-1:0]         digit_at_max
);

  localparam int W = NUM_DIGITS * DIGIT_W;

  logic [W-1:0]          count_q;
  logic [W-1:0]          count_d;
  logic [NUM_DIGITS-1:0] at_max_s;
  logic [NUM_DIGITS-1:0] at_zero_s;
  logic                  up_s;
  logic                  dn_s;

  // Per-digit max / zero flags of the current count
  always_comb begin
    at_max_s  = '0;
    at_zero_s = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      at_max_s[i]  = (count_q[i*DIGIT_W +: DIGIT_W] == DIGIT_MAX[i*DIGIT_W +: DIGIT_W]);
      at_zero_s[i] = (count_q[i*DIGIT_W +: DIGIT_W] == '0);
    end
  end

  // Qualified step requests: reset and load both suppress counting
  assign up_s = inc & ~dec & ~load & ~reset;
  assign dn_s = dec & ~inc & ~load & ~reset;

  assign carry_out    = up_s & (&at_max_s);
  assign borrow_out   = dn_s & (&at_zero_s);
  assign digit_at_max = at_max_s;
  assign q            = count_q;

  // Next count: a digit moves only when every lower digit is at its wrap point
  always_comb begin
    logic                up_run;
    logic                dn_run;
    logic [DIGIT_W-1:0]  cur;
    logic [DIGIT_W-1:0]  mx;
    logic [DIGIT_W-1:0]  lv;
    count_d = count_q;
    up_run  = 1'b1;
    dn_run  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cur = count_q[i*DIGIT_W +: DIGIT_W];
      mx  = DIGIT_MAX[i*DIGIT_W +: DIGIT_W];
      lv  = load_val[i*DIGIT_W +: DIGIT_W];
      if (load) begin
        count_d[i*DIGIT_W +: DIGIT_W] = (lv <= mx) ? lv : '0;
      end else if (up_s && up_run) begin
        count_d[i*DIGIT_W +: DIGIT_W] = (cur == mx) ? '0 : cur + 1'b1;
      end else if (dn_s && dn_run) begin
        count_d[i*DIGIT_W +: DIGIT_W] = (cur == '0) ? mx : cur - 1'b1;
      end else begin
        count_d[i*DIGIT_W +: DIGIT_W] = cur;
      end
      up_run = up_run & at_max_s[i];
      dn_run = dn_run & at_zero_s[i];
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

`ifdef MODN_CASCADE_CMP_EN
  logic match_q;
  logic step_s;

  assign step_s = load | up_s | dn_s;
  assign match  = match_q;

  // Match fires only on the edge that moves q onto cmp_val, never while holding
  always_ff @(posedge clk) begin
    if (reset) begin
      match_q <= 1'b0;
    end else begin
      match_q <= step_s && (count_d == cmp_val);
    end
  end
`endif

endmodule

// File: doc/modn_cascade_counter.md
Name: modn_cascade_counter

Overview:
- Parametrised chain of cascaded modulo-N digit counters. Example: MM:SS display counting 00:00..59:59.
- Generalises the single mod-6 stage. Adds:
  - digit count and per-digit modulus as parameters
  - up and down counting
  - parallel load
  - chain carry and borrow outputs
- Sits between the tick/debounce logic and the seven-segment display mux. Also cascades into further counter instances.

Parameters:
- NUM_DIGITS, 4, number of cascaded digit stages (1..8).
- DIGIT_W, 4, bits per digit (2..8).
- DIGIT_MAX, 16'h5959, packed NUM_DIGITS*DIGIT_W vector. Field i, bits [i*DIGIT_W +: DIGIT_W], is the max value of digit i (modulus - 1). Each field must be >= 1. Digit 0 is least significant.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clock clk
- inc  in  1  count-up request, one step per cycle
- dec  in  1  count-down request, one step per cycle
- load  in  1  parallel load strobe
- load_val  in  NUM_DIGITS*DIGIT_W  packed digit values for load
- q  out  NUM_DIGITS*DIGIT_W  registered packed digit values
- carry_out  out  1  combinational: inc step wraps the whole chain
- borrow_out  out  1  combinational: dec step wraps the whole chain
- digit_at_max  out  NUM_DIGITS  combinational: bit i = (digit i == its max)

Behaviour:
- Priority at each rising clk: reset > load > (inc XOR dec) > hold.
- Reset: all digits 0 on the next edge. Overrides load/inc/dec in the same cycle. Mid-count reset discards the count; no carry or borrow is generated by the reset itself.
- Load: digit i <= load_val field i if that field <= its max; otherwise digit i <= 0. Each digit is sanitised independently. Load takes effect at the next edge. inc/dec in the same cycle are ignored.
- inc=1, dec=1 together: no change, carry_out=0, borrow_out=0.
- Up step (inc & ~dec):
  - Digit i advances when all digits 0..i-1 are at max. Digit 0 always advances.
  - An advancing digit at its max wraps to 0; otherwise it increments by 1.
  - All changes land in the same edge. No ripple latency, single-cycle update of the whole chain.
- Down step (dec & ~inc):
  - Digit i moves when all digits 0..i-1 are 0.
  - An advancing digit at 0 wraps to its max; otherwise it decrements by 1.
- carry_out = inc & ~dec & ~load & ~reset & (every digit at max). It is high in the cycle before the chain wraps to all-zero.
- borrow_out = dec & ~inc & ~load & ~reset & (every digit == 0).
- carry_out/borrow_out are one-cycle qualified pulses. They are suitable for driving inc/dec of a downstream instance directly.
- Digit values never exceed their max except transiently at power-up before the first reset. Behaviour before the first reset is undefined.
- Arithmetic is per-digit, unsigned, DIGIT_W bits. No binary carry between fields.
- Outputs after reset: q=0, carry_out=0, borrow_out=0 (given inc=dec=0). digit_at_max=0 because every max is >= 1.
- Latency: q reflects a request one edge later. carry_out/borrow_out/digit_at_max are same-cycle combinational.

Optional Feature:
- Macro MODN_CASCADE_CMP_EN.
- Defined:
  - Adds input cmp_val (NUM_DIGITS*DIGIT_W).
  - Adds output match (1, registered).
  - match <= 1 on an edge where q changes (load, up step or down step) and the new q equals cmp_val. Otherwise match <= 0. It is therefore a one-cycle pulse aligned with the new q.
  - Reset forces match=0, even if cmp_val is 0.
  - Holding q at cmp_val does not re-fire.
- Not defined: cmp_val and match do not exist. No compare logic is synthesised.

Test Plan:
- reset then 3600 inc cycles with default params → q steps 0000..5959. On the cycle q=16'h5959 with inc=1, carry_out=1 and the next q=16'h0000. carry_out is seen exactly once.
- From q=16'h0000, one dec → borrow_out=1 that cycle; next q=16'h5959. One more dec → q=16'h5958.
- load with load_val=16'h3A7C → digits: 3<=5 kept, A>9→0, 7>5→0, C>9→0; q=16'h3000. load with inc=1 in the same cycle → load wins, no step.
- q=16'h0959, inc=dec=1 → q unchanged, carry_out=0. Then reset=1 with inc=1 → q=0, carry_out=0.
- NUM_DIGITS=2, DIGIT_W=3, DIGIT_MAX=6'o25 → q sequence 00,01,...,05,10,...,25,00; carry_out only on 25→00.
- MODN_CASCADE_CMP_EN, cmp_val=16'h0010 → incrementing from 0009: match=1 for exactly one cycle with q=0010; holding q there → match=0; reset → match=0.
